// File: rtl/regfile_dumper.sv
// ============================================================================
// regfile_dumper : walks a wrap-around register range and streams (addr, data)
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_dumper #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_first_addr,
   input  logic [ADDR_W-1:0] i_last_addr,
   output logic [ADDR_W-1:0] o_rf_addr,
   input  logic [DATA_W-1:0] i_rf_data,
   output logic              o_dump_valid,
   input  logic              i_dump_ready,
   output logic [ADDR_W-1:0] o_dump_addr,
   output logic [DATA_W-1:0] o_dump_data,
   output logic              o_dump_last,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cur;
   logic [ADDR_W-1:0] r_last_addr;
   logic [ADDR_W-1:0] r_rf_addr;
   logic [ADDR_W-1:0] r_dump_addr;
   logic [DATA_W-1:0] r_dump_data;
   logic              r_dump_last;
   logic              r_dump_valid;
   logic              r_busy;
   logic              r_done;

   // Every output is a register updated alongside the state transition, so
   // i_dump_ready never reaches an output combinationally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cur        <= '0;
         r_last_addr  <= '0;
         r_rf_addr    <= '0;
         r_dump_addr  <= '0;
         r_dump_data  <= '0;
         r_dump_last  <= 1'b0;
         r_dump_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state     <= S_READ;
                  r_cur       <= i_first_addr;
                  r_last_addr <= i_last_addr;
                  r_rf_addr   <= i_first_addr;
                  r_busy      <= 1'b1;
               end
            end
            S_READ: begin
               r_rf_addr <= '0;
               if (i_abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state      <= S_SEND;
                  r_dump_data  <= i_rf_data;
                  r_dump_addr  <= r_cur;
                  r_dump_last  <= (r_cur == r_last_addr);
                  r_dump_valid <= 1'b1;
               end
            end
            S_SEND: begin
               if (i_abort) begin
                  r_state      <= S_IDLE;
                  r_dump_valid <= 1'b0;
                  r_dump_last  <= 1'b0;
                  r_busy       <= 1'b0;
               end else if (i_dump_ready) begin
                  r_dump_valid <= 1'b0;
                  r_dump_last  <= 1'b0;
                  if (r_dump_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= S_READ;
                     r_cur     <= r_cur + 1'b1;
                     r_rf_addr <= r_cur + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_rf_addr    = r_rf_addr;
   assign o_dump_valid = r_dump_valid;
   assign o_dump_addr  = r_dump_addr;
   assign o_dump_data  = r_dump_data;
   assign o_dump_last  = r_dump_last;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

`default_nettype wire
